// File: rtl/irq_ctrl_if.sv
// CPU-side MMIO bus and interrupt vector handshake for irq_ctrl.
// The CPU drives the master modport; the controller uses the slave modport.
interface irq_ctrl_if #(
    parameter int ID_W = 3
);
    logic [15:0]     a;
    logic [7:0]      din;
    logic [7:0]      dout;
    logic            rd;
    logic            wr;
    logic            sel;
    logic            cpu_irq;
    logic [ID_W-1:0] cpu_irq_id;
    logic            cpu_irq_ack;
    logic [ID_W-1:0] cpu_ack_id;
    logic            wake;

    modport master (
        output a, din, rd, wr, cpu_irq_ack, cpu_ack_id,
        input  dout, sel, cpu_irq, cpu_irq_id, wake
    );

    modport slave (
        input  a, din, rd, wr, cpu_irq_ack, cpu_ack_id,
        output dout, sel, cpu_irq, cpu_irq_id, wake
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: IE/IF/IM registers, level/edge trigger detection,
// fixed priority (bit 0 highest) and a CPU acknowledge handshake.
module irq_ctrl #(
    parameter int                 NUM_IRQ  = 5,
    parameter int                 ID_W     = 3,
    parameter logic [15:0]        ADDR_IE  = 16'hFFFF,
    parameter logic [15:0]        ADDR_IF  = 16'hFF0F,
    parameter logic [15:0]        ADDR_IM  = 16'hFF7F,
    parameter logic [NUM_IRQ-1:0] IM_RESET = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] req,
    irq_ctrl_if.slave          bus
);

    logic [NUM_IRQ-1:0] ie_q, ie_d;
    logic [NUM_IRQ-1:0] if_q, if_d;
    logic [NUM_IRQ-1:0] im_q, im_d;
    logic [NUM_IRQ-1:0] req_q, req_d;
    logic [NUM_IRQ-1:0] hit;
    logic [NUM_IRQ-1:0] pend;
    logic               sel_ie, sel_if, sel_im;
    logic               ack_ok;
    logic [ID_W-1:0]    irq_id;
    logic [7:0]         rdata;
    logic               unused_bus;

    assign sel_ie = (bus.a == ADDR_IE);
    assign sel_if = (bus.a == ADDR_IF);
    assign sel_im = (bus.a == ADDR_IM);
    assign pend   = ie_q & if_q;

    // Edge-mode bits only hit on a rising request; req_q resets low so a
    // request held through reset release is seen as an edge.
    assign hit    = req & ~(im_q & req_q);
    assign ack_ok = bus.cpu_irq_ack & (|pend);

    always_comb begin
        req_d = req;
        ie_d  = ie_q;
        im_d  = im_q;
        if (bus.wr && sel_ie) ie_d = bus.din[NUM_IRQ-1:0];
        if (bus.wr && sel_im) im_d = bus.din[NUM_IRQ-1:0];
        if_d = if_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (hit[i])
                if_d[i] = 1'b1;
            else if (bus.wr && sel_if)
                if_d[i] = bus.din[i];
            else if (ack_ok && (bus.cpu_ack_id == ID_W'(i)))
                if_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie_q  <= '0;
            if_q  <= '0;
            im_q  <= IM_RESET;
            req_q <= '0;
        end else begin
            ie_q  <= ie_d;
            if_q  <= if_d;
            im_q  <= im_d;
            req_q <= req_d;
        end
    end

    always_comb begin
        irq_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) irq_id = ID_W'(i);
        end
    end

    // IF reads include this cycle's hits so a request is visible immediately.
    always_comb begin
        rdata = 8'hFF;
        if (sel_ie) begin
            rdata = 8'(ie_q);
        end else if (sel_if) begin
            rdata = 8'hFF;
            rdata[NUM_IRQ-1:0] = if_q | hit;
        end else if (sel_im) begin
            rdata = 8'(im_q);
        end
    end

    assign bus.dout       = rdata;
    assign bus.sel        = sel_ie | sel_if | sel_im;
    assign bus.cpu_irq    = |pend;
    assign bus.cpu_irq_id = irq_id;
    assign bus.wake       = |pend;

    assign unused_bus = &{1'b0, bus.rd, bus.din};

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl with NUM_IRQ = 5.
module tb_irq_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    int         errors;
    int         checks;

    irq_ctrl_if #(.ID_W(3)) bus ();

    irq_ctrl #(.NUM_IRQ(5), .ID_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .req (req),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
        bus.a   = addr;
        bus.din = data;
        bus.wr  = 1'b1;
        tick();
        bus.wr  = 1'b0;
    endtask

    task automatic rd_reg(input logic [15:0] addr, output logic [7:0] data);
        bus.a  = addr;
        bus.rd = 1'b1;
        #1;
        data   = bus.dout;
        bus.rd = 1'b0;
    endtask

    task automatic do_ack(input logic [2:0] id);
        bus.cpu_irq_ack = 1'b1;
        bus.cpu_ack_id  = id;
        tick();
        bus.cpu_irq_ack = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b0;
        #3;
        checks++;
        if (bus.cpu_irq !== 1'b0 || bus.wake !== 1'b0 || bus.cpu_irq_id !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: irq=%b wake=%b id=%0d, expected 0 0 0",
                     bus.cpu_irq, bus.wake, bus.cpu_irq_id);
        end
        tick();
        rst = 1'b1;
        tick();
        rd_reg(16'hFFFF, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_ie: got %h expected 00", d); end
        checks++;
        if (bus.sel !== 1'b1) begin errors++; $display("FAIL sel_ie: got %b expected 1", bus.sel); end
        rd_reg(16'hFF0F, d);
        checks++;
        if (d !== 8'hE0) begin errors++; $display("FAIL reset_if: got %h expected E0", d); end
        rd_reg(16'hFF7F, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_im: got %h expected 00", d); end
        rd_reg(16'hFF10, d);
        checks++;
        if (d !== 8'hFF || bus.sel !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_read: dout=%h sel=%b expected FF 0", d, bus.sel);
        end
    endtask

    task automatic test_single();
        logic [7:0] d;
        wr_reg(16'hFFFF, 8'h1F);
        req = 5'b00100;
        rd_reg(16'hFF0F, d);
        checks++;
        if (d !== 8'hE4) begin errors++; $display("FAIL if_bypass: got %h expected E4", d); end
        checks++;
        if (bus.cpu_irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b expected 0", bus.cpu_irq); end
        tick();
        req = 5'b00000;
        rd_reg(16'hFF0F, d);
        checks++;
        if (d !== 8'hE4 || bus.cpu_irq !== 1'b1 || bus.cpu_irq_id !== 3'd2) begin
            errors++;
            $display("FAIL single_set: if=%h irq=%b id=%0d expected E4 1 2", d, bus.cpu_irq, bus.cpu_irq_id);
        end
        do_ack(3'd2);
        rd_reg(16'hFF0F, d);
        checks++;
        if (d !== 8'hE0 || bus.cpu_irq !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: if=%h irq=%b expected E0 0", d, bus.cpu_irq);
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp_id [3];
        exp_id[0] = 3'd1;
        exp_id[1] = 3'd2;
        exp_id[2] = 3'd4;
        req = 5'b10110;
        tick();
        req = 5'b00000;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.cpu_irq !== 1'b1 || bus.cpu_irq_id !== exp_id[k]) begin
                errors++;
                $display("FAIL priority_%0d: irq=%b id=%0d expected 1 %0d", k, bus.cpu_irq, bus.cpu_irq_id, exp_id[k]);
            end
            do_ack(exp_id[k]);
        end
        checks++;
        if (bus.cpu_irq !== 1'b0) begin errors++; $display("FAIL priority_drain: irq=%b expected 0", bus.cpu_irq); end
    endtask

    task automatic test_bad_ack();
        logic [7:0] d;
        req = 5'b10000;
        tick();
        req = 5'b00000;
        do_ack(3'd5);
        do_ack(3'd7);
        checks++;
        if (bus.cpu_irq !== 1'b1 || bus.cpu_irq_id !== 3'd4) begin
            errors++;
            $display("FAIL ack_out_of_range: irq=%b id=%0d expected 1 4", bus.cpu_irq, bus.cpu_irq_id);
        end
        do_ack(3'd4);
        wr_reg(16'hFFFF, 8'h00);
        wr_reg(16'hFF0F, 8'h01);
        do_ack(3'd0);
        rd_reg(16'hFF0F, d);
        checks++;
        if (d !== 8'hE1) begin errors++; $display("FAIL ack_without_irq: if=%h expected E1", d); end
        wr_reg(16'hFF0F, 8'h00);
        wr_reg(16'hFFFF, 8'h1F);
    endtask

    task automatic test_trigger_mode();
        logic [7:0] d;
        int         hi_cnt;
        wr_reg(16'hFF7F, 8'h01);
        rd_reg(16'hFF7F, d);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL im_readback: got %h expected 01", d); end
        hi_cnt = 0;
        req = 5'b00001;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) do_ack(3'd0); else tick();
            if (bus.cpu_irq === 1'b1) hi_cnt++;
        end
        rd_reg(16'hFF0F, d);
        checks++;
        if (hi_cnt != 3 || d !== 8'hE0) begin
            errors++;
            $display("FAIL edge_mode: irq_cycles=%0d if=%h expected 3 E0", hi_cnt, d);
        end
        req = 5'b00000;
        tick();
        wr_reg(16'hFF7F, 8'h00);
        hi_cnt = 0;
        req = 5'b00001;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) do_ack(3'd0); else tick();
            if (c == 4) begin
                rd_reg(16'hFF0F, d);
                checks++;
                if (d !== 8'hE1) begin errors++; $display("FAIL level_after_ack: if=%h expected E1", d); end
            end
            if (bus.cpu_irq === 1'b1) hi_cnt++;
        end
        checks++;
        if (hi_cnt != 10) begin errors++; $display("FAIL level_mode: irq_cycles=%0d expected 10", hi_cnt); end
        req = 5'b00000;
        tick();
        do_ack(3'd0);
        checks++;
        if (bus.cpu_irq !== 1'b0) begin errors++; $display("FAIL level_clear: irq=%b expected 0", bus.cpu_irq); end
    endtask

    task automatic test_collision();
        logic [7:0] d;
        wr_reg(16'hFF0F, 8'h08);
        bus.a           = 16'hFF0F;
        bus.din         = 8'h00;
        bus.wr          = 1'b1;
        bus.cpu_irq_ack = 1'b1;
        bus.cpu_ack_id  = 3'd3;
        req             = 5'b01000;
        #1;
        d = bus.dout;
        checks++;
        if (d !== 8'hE8) begin errors++; $display("FAIL collision_read: got %h expected E8", d); end
        tick();
        bus.wr          = 1'b0;
        bus.cpu_irq_ack = 1'b0;
        req             = 5'b00000;
        rd_reg(16'hFF0F, d);
        checks++;
        if (d !== 8'hE8 || bus.cpu_irq_id !== 3'd3) begin
            errors++;
            $display("FAIL collision_result: if=%h id=%0d expected E8 3", d, bus.cpu_irq_id);
        end
        wr_reg(16'hFF0F, 8'h00);
    endtask

    task automatic test_wake_reset();
        logic [7:0] d;
        wr_reg(16'hFFFF, 8'h00);
        wr_reg(16'hFF0F, 8'h04);
        checks++;
        if (bus.cpu_irq !== 1'b0 || bus.wake !== 1'b0) begin
            errors++;
            $display("FAIL wake_disabled: irq=%b wake=%b expected 0 0", bus.cpu_irq, bus.wake);
        end
        wr_reg(16'hFFFF, 8'h04);
        checks++;
        if (bus.wake !== 1'b1 || bus.cpu_irq !== 1'b1 || bus.cpu_irq_id !== 3'd2) begin
            errors++;
            $display("FAIL wake_enabled: wake=%b irq=%b id=%0d expected 1 1 2", bus.wake, bus.cpu_irq, bus.cpu_irq_id);
        end
        wr_reg(16'hFF7F, 8'h1F);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.cpu_irq !== 1'b0 || bus.wake !== 1'b0 || bus.cpu_irq_id !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: irq=%b wake=%b id=%0d expected 0 0 0", bus.cpu_irq, bus.wake, bus.cpu_irq_id);
        end
        rd_reg(16'hFFFF, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL async_reset_ie: got %h expected 00", d); end
        rd_reg(16'hFF0F, d);
        checks++;
        if (d !== 8'hE0) begin errors++; $display("FAIL async_reset_if: got %h expected E0", d); end
        rd_reg(16'hFF7F, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL async_reset_im: got %h expected 00", d); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        rst             = 1'b0;
        req             = 5'b00000;
        bus.a           = 16'h0000;
        bus.din         = 8'h00;
        bus.rd          = 1'b0;
        bus.wr          = 1'b0;
        bus.cpu_irq_ack = 1'b0;
        bus.cpu_ack_id  = 3'd0;
        test_reset();
        test_single();
        test_priority();
        test_bad_ack();
        test_trigger_mode();
        test_collision();
        test_wake_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
